// File: rtl/regfile_pkg.sv
// Shared defaults, clog2 helper and read-address bus type for the regfile scoreboard.
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int CW_DEF    = 2;
  localparam int NREAD_DEF = 2;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  localparam int AW_DEF = clog2(NREGS_DEF);

  typedef logic [NREAD_DEF*AW_DEF-1:0] rd_addr_bus_t;

endpackage

`default_nettype wire

// File: rtl/rf_pending_cnt.sv
// Per-register pending-write counter: saturating increment, floor-at-zero decrement.
`default_nettype none

module rf_pending_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          underflow
);

  logic full;
  logic inc_ok;
  logic dec_ok;

  assign full   = &cnt;
  assign inc_ok = inc && !full;
  assign dec_ok = dec && (cnt != '0);
  // A same-cycle reservation covers a write-back that would otherwise find no producer.
  assign underflow = dec && (cnt == '0) && !inc_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(inc_ok) - CW'(dec_ok);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with N read ports, one write-back port, optional bypass
// and a per-register pending-write scoreboard.
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  XLEN   = XLEN_DEF,
  parameter int  NREGS  = NREGS_DEF,
  parameter int  NREAD  = NREAD_DEF,
  parameter int  BYPASS = 1,
  parameter int  CW     = CW_DEF,
  localparam int AW     = clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_ready,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  wr_err
);

  logic [XLEN-1:0]            mem [1:NREGS-1];
  logic [NREGS-1:0][CW-1:0]   cnt;
  logic [NREGS-1:0]           uflow;

  assign cnt[0]   = '0;
  assign uflow[0] = 1'b0;

  generate
    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      logic iss_hit;
      logic wr_hit;

      assign iss_hit = iss_en && (iss_addr == AW'(r));
      assign wr_hit  = wr_en && (wr_addr == AW'(r));

      rf_pending_cnt #(.CW(CW)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (iss_hit),
        .dec       (wr_hit),
        .cnt       (cnt[r]),
        .underflow (uflow[r])
      );
    end
  endgenerate

  // Purely a function of the stored count so that iss_en never reaches an output.
  assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (|uflow) begin
      wr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  generate
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            hit;
      logic [CW-1:0]   pend;
      logic [XLEN-1:0] data;
      logic            busy;

      assign addr = rd_addr[k*AW +: AW];
      assign hit  = wr_en && (wr_addr == addr) && (addr != '0);
      assign pend = cnt[addr];

      always_comb begin
        data = '0;
        busy = 1'b0;
        if (rst && (addr != '0)) begin
          if ((BYPASS != 0) && hit) data = wr_data;
          else                      data = mem[addr];
          // With forwarding, the last outstanding producer retiring this cycle frees the operand.
          if (BYPASS != 0) busy = (pend != '0) && !(hit && (pend == CW'(1)));
          else             busy = (pend != '0);
        end
      end

      assign rd_data[k*XLEN +: XLEN] = data;
      assign rd_busy[k]              = busy;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard; runs a BYPASS=1 and a BYPASS=0 copy in lockstep.
`default_nettype none

module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic         clk;
  logic         rst;
  rd_addr_bus_t rd_addr;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;

  logic [63:0]  b_rd_data, n_rd_data;
  logic [1:0]   b_rd_busy, n_rd_busy;
  logic         b_iss_ready, n_iss_ready;
  logic         b_wr_err, n_wr_err;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(.BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(b_iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(b_wr_err)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(n_rd_data), .rd_busy(n_rd_busy),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(n_iss_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(n_wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        rdy;
    logic        err;
    logic [31:0] nd1;
    logic        nbusy1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic ie, input logic [4:0] ia,
                     input logic [4:0] ra0, input logic [4:0] ra1,
                     input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] busy,
                     input logic rdy, input logic err,
                     input logic [31:0] nd1, input logic nbusy1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0; v.d1 = d1; v.busy = busy; v.rdy = rdy; v.err = err; v.nd1 = nd1; v.nbusy1 = nbusy1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0; iss_en = 1'b0; iss_addr = 5'd0;
  endtask

  initial begin
    rst = 1'b0;
    rd_addr = '0;
    idle();

    // x5 reserved then written with bypass vs. no bypass
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 5'd0, 5'd5, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0);
    add(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 32'h0,        1'b1);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    // x7 to saturation, refused fourth issue, three write-backs
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 32'h0,        1'b1);
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        2'b10, 1'b1, 1'b0, 32'h0,        1'b1);
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd0, 5'd7, 32'h0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h0,        1'b1);
    add(1'b1, 5'd7, 32'h11,       1'b0, 5'd7, 5'd0, 5'd7, 32'h0,        32'h11,       2'b10, 1'b0, 1'b0, 32'h0,        1'b1);
    add(1'b1, 5'd7, 32'h22,       1'b0, 5'd7, 5'd0, 5'd7, 32'h0,        32'h22,       2'b10, 1'b1, 1'b0, 32'h11,       1'b1);
    add(1'b1, 5'd7, 32'h33,       1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h33,       2'b00, 1'b1, 1'b0, 32'h22,       1'b1);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h33,       2'b00, 1'b1, 1'b0, 32'h33,       1'b0);
    // x3: simultaneous issue and write-back at cnt=1
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd0, 5'd3, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0);
    add(1'b1, 5'd3, 32'hA5,       1'b1, 5'd3, 5'd0, 5'd3, 32'h0,        32'hA5,       2'b00, 1'b1, 1'b0, 32'h0,        1'b1);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'hA5,       2'b10, 1'b1, 1'b0, 32'hA5,       1'b1);
    add(1'b1, 5'd3, 32'h5A,       1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h5A,       2'b00, 1'b1, 1'b0, 32'hA5,       1'b1);
    // x0 writes and issues are ignored
    add(1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b1, 1'b0, 32'h0,        1'b0);
    // x4: write-back with cnt=0 covered by same-cycle issue, no error
    add(1'b1, 5'd4, 32'h44,       1'b1, 5'd4, 5'd0, 5'd3, 32'h0,        32'h5A,       2'b00, 1'b1, 1'b0, 32'h5A,       1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd4, 5'd4, 32'h44,       32'h44,       2'b11, 1'b1, 1'b0, 32'h44,       1'b1);
    add(1'b1, 5'd4, 32'h45,       1'b0, 5'd0, 5'd0, 5'd4, 32'h0,        32'h45,       2'b00, 1'b1, 1'b0, 32'h44,       1'b1);
    // x9: underflow sets the sticky error
    add(1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd0, 5'd4, 32'h0,        32'h45,       2'b00, 1'b1, 1'b0, 32'h45,       1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00, 1'b1, 1'b1, 32'h99,       1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd0, 5'd9, 32'h0,        32'h99,       2'b00, 1'b1, 1'b1, 32'h99,       1'b0);
    add(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h99,       2'b10, 1'b1, 1'b1, 32'h99,       1'b1);

    // Reset state, sampled while rst is still low
    rd_addr = {5'd5, 5'd7};
    iss_addr = 5'd7;
    #2;
    check("reset rd_data", b_rd_data[31:0] | b_rd_data[63:32] | n_rd_data[31:0], 32'h0);
    check("reset rd_busy", 32'(b_rd_busy | n_rd_busy), 32'h0);
    check("reset iss_ready", 32'(b_iss_ready & n_iss_ready), 32'h1);
    check("reset wr_err", 32'(b_wr_err | n_wr_err), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      iss_en = vecs[i].ie; iss_addr = vecs[i].ia;
      rd_addr = {vecs[i].ra1, vecs[i].ra0};
      #2;
      check($sformatf("v%0d b_d0", i), b_rd_data[31:0], vecs[i].d0);
      check($sformatf("v%0d b_d1", i), b_rd_data[63:32], vecs[i].d1);
      check($sformatf("v%0d b_busy", i), 32'(b_rd_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d b_ready", i), 32'(b_iss_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d n_ready", i), 32'(n_iss_ready), 32'(vecs[i].rdy));
      check($sformatf("v%0d b_err", i), 32'(b_wr_err), 32'(vecs[i].err));
      check($sformatf("v%0d n_err", i), 32'(n_wr_err), 32'(vecs[i].err));
      check($sformatf("v%0d n_d1", i), n_rd_data[63:32], vecs[i].nd1);
      check($sformatf("v%0d n_busy1", i), 32'(n_rd_busy[1]), 32'(vecs[i].nbusy1));
      @(posedge clk); #1;
    end

    // Mid-cycle asynchronous reset with a write-back held across the reset edge
    idle();
    rd_addr = {5'd5, 5'd9};
    #2;
    check("pre-reset x9", b_rd_data[31:0], 32'h99);
    check("pre-reset x5", n_rd_data[63:32], 32'hDEADBEEF);
    #1;
    rst = 1'b0;
    #1;
    check("async rst rd_data", b_rd_data[31:0] | b_rd_data[63:32] | n_rd_data[31:0] | n_rd_data[63:32], 32'h0);
    check("async rst rd_busy", 32'(b_rd_busy | n_rd_busy), 32'h0);
    check("async rst wr_err", 32'(b_wr_err | n_wr_err), 32'h0);
    iss_addr = 5'd9;
    #1;
    check("async rst iss_ready", 32'(b_iss_ready), 32'h1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFF;
    @(posedge clk); #1;
    idle();
    #1;
    rst = 1'b1;
    #1;
    check("post-rst x9", b_rd_data[31:0], 32'h0);
    check("post-rst x5", n_rd_data[63:32], 32'h0);
    check("post-rst busy", 32'(b_rd_busy | n_rd_busy), 32'h0);
    check("post-rst wr_err", 32'(b_wr_err), 32'h0);
    @(posedge clk); #1;
    check("post-rst x9 next", n_rd_data[31:0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
